tpm_response_builder: RTL
=========================

# tpm_response_builder

Serialises a completed TPM response into the byte stream returned to the host. Sits directly downstream of the execution engine and management module: on the execution engine's `response_valid` pulse it captures the final response code and tag, emits the 10-byte big-endian TPM response header (tag, responseSize, responseCode), then forwards the response-parameter bytes from the parameter source. Its output feeds the SPI I/O block's read FIFO.

## Interface

Parameters:
- `MAX_RSP_SIZE`, default 4096: largest legal total response size in bytes, header included.

Ports:
- `clock`  in  1: system clock, 50 MHz.
- `reset`  in  1: synchronous, active-high.
- `response_valid`  in  1: one-cycle pulse; the response is complete.
- `response_code`  in  32: final TPM_RC, management module `tpm_rc`.
- `response_tag`  in  16: TPM_ST tag to return.
- `payload_size`  in  16: number of parameter bytes following the header.
- `pl_data`  in  8: parameter byte.
- `pl_valid`  in  1: `pl_data` is valid.
- `pl_ready`  out  1: parameter byte consumed this cycle.
- `out_data`  out  8: response byte to the I/O FIFO.
- `out_valid`  out  1: `out_data` is valid.
- `out_last`  out  1: `out_data` is the final byte of the response.
- `out_ready`  in  1: I/O FIFO accepts the byte.
- `busy`  out  1: a response is being built.
- `drop_err`  out  1: one-cycle pulse; `response_valid` arrived while busy.

## Operation

- States: IDLE, HDR, PAYLOAD, DRAIN.
- IDLE: on `response_valid`, latch code, tag and payload_size; compute size = 10 + payload_size as 32-bit zero-extended; go to HDR with byte index 0.
- Oversize: if 10 + payload_size > `MAX_RSP_SIZE`, latched code becomes 0x00000095 (TPM_RC_SIZE), tag becomes 0x8001, size becomes 10, and the payload is drained.
- HDR: bytes 0-9 in order: tag[15:8], tag[7:0], size[31:24] .. size[7:0], rc[31:24] .. rc[7:0]. The index advances only on `out_valid && out_ready`.
- After byte 9 is accepted:
  - payload_size = 0: return to IDLE.
  - drain required: go to DRAIN.
  - otherwise: go to PAYLOAD.
- PAYLOAD: combinational pass-through.
  - `out_data = pl_data`, `out_valid = pl_valid`, `pl_ready = out_ready`.
  - A 16-bit counter counts transfers.
  - After payload_size transfers, return to IDLE.
- DRAIN: `pl_ready = 1`, `out_valid = 0`. Consume and discard payload_size bytes, then return to IDLE.
- `out_last`:
  - High on byte 9 when the emitted size is 10.
  - Otherwise high on the final payload byte.
- `busy` is high in every state except IDLE.
- `response_valid` while busy: ignored, `drop_err` pulses for one cycle, and the current response continues unaffected.
- `pl_ready` = 0 in IDLE and HDR.

## Timing

- Reset: state IDLE; counters 0; `out_valid`, `out_last`, `pl_ready`, `busy`, `drop_err` = 0; `out_data` = 0x00.
- Reset mid-response abandons the response with no further bytes; the upstream FIFO must be cleared by the same reset.
- Latency: header byte 0 is presented with `out_valid` on the cycle after the `response_valid` pulse.
- HDR handshake: `out_data` and `out_last` hold stable while `out_valid && !out_ready`.
- Throughput: one byte per cycle when `out_ready` and `pl_valid` are held high.
- Response sizes:
  - Header-only response: 10 cycles of output.
  - N-byte payload: 10+N cycles.
- Last transfer:
  - Back in IDLE the cycle after the last transfer; `busy` falls then.
  - A `response_valid` in that same last-transfer cycle is dropped with `drop_err`.

## Configuration

- `TPM_RSP_ERR_TRIM_EN` defined: any latched response_code ≠ 0 is handled like the oversize case:
  - Tag forced to 0x8001.
  - Size 10.
  - Header only; the payload is drained.
- Undefined: non-zero codes are emitted with the given tag, size and payload unchanged. Only oversize forces trimming.

## Test plan

- Startup success: rc=0, tag=0x8001, payload_size=0 -> bytes 80 01 00 00 00 0A 00 00 00 00; `out_last` on byte 9; `busy` low next cycle.
- GetRandom-like: tag=0x8001, payload_size=4, payload AA BB CC DD -> header 80 01 00 00 00 0E 00 00 00 00, then AA BB CC DD; `out_last` only on DD.
- Backpressure: `out_ready` toggling 1-0-0-1 and `pl_valid` gaps -> identical byte sequence, no duplicates or drops, data stable while stalled.
- Oversize: payload_size=4090 with `MAX_RSP_SIZE`=4096 -> 80 01 00 00 00 0A 00 00 00 95; 4090 bytes drained; no output payload.
- Error trim:
  - Stimulus: rc=0x00000101, tag=0x8002, payload_size=6.
  - With macro: 80 01 … 0A 00 00 01 01, 6 bytes drained.
  - Without macro: 80 02 00 00 00 10 00 00 01 01 + 6 bytes.
- Collision/reset:
  - `response_valid` during HDR -> `drop_err` one pulse, original stream intact.
  - `reset` asserted mid-payload -> all outputs 0 the next cycle, IDLE.

Source files
------------

// File: rtl/tpm_response_builder.sv
// tpm_response_builder
//   Turns a completed TPM response into the byte stream sent back to the host.
//   It first emits the 10-byte big-endian header (tag, responseSize,
//   responseCode) and then passes the parameter bytes through.
//
//   Optional build macro: TPM_RSP_ERR_TRIM_EN. When it is defined, any response
//   with a non-zero response code is cut down to a header-only error reply.
//
// Ports
//   clock, reset      system clock; synchronous active-high reset
//   response_valid    one-cycle pulse: the response is complete
//   response_code     final TPM_RC to return
//   response_tag      TPM_ST tag to return
//   payload_size      number of parameter bytes that follow the header
//   pl_data/pl_valid  parameter byte source
//   pl_ready          parameter byte consumed this cycle
//   out_data/out_valid/out_last/out_ready   byte stream to the I/O FIFO
//   busy              a response is in progress
//   drop_err          one-cycle pulse: response_valid arrived while busy
module tpm_response_builder #(
  parameter int unsigned MAX_RSP_SIZE = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        response_valid,
  input  logic [31:0] response_code,
  input  logic [15:0] response_tag,
  input  logic [15:0] payload_size,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic        busy,
  output logic        drop_err
);

  localparam int unsigned HDR_LEN = 10;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD, S_DRAIN} state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [15:0] r_cnt;
  logic [15:0] r_len;
  logic [15:0] r_tag;
  logic [31:0] r_size;
  logic [31:0] r_rc;
  logic        r_drain;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_out_last;
  logic        r_drop_err;

  logic [16:0] w_total;
  logic        w_oversize;
  logic        w_trim;
  logic [31:0] w_rc_n;
  logic [15:0] w_tag_n;
  logic [31:0] w_size_n;
  logic        w_hdr_fire;
  logic        w_pl_fire;
  logic        w_cnt_last;

  // Header byte selected by index, most significant byte of each field first.
  function automatic logic [7:0] hdr_byte(input logic [3:0]  idx,
                                          input logic [15:0] tag,
                                          input logic [31:0] size,
                                          input logic [31:0] rc);
    case (idx)
      4'd0:    hdr_byte = tag[15:8];
      4'd1:    hdr_byte = tag[7:0];
      4'd2:    hdr_byte = size[31:24];
      4'd3:    hdr_byte = size[23:16];
      4'd4:    hdr_byte = size[15:8];
      4'd5:    hdr_byte = size[7:0];
      4'd6:    hdr_byte = rc[31:24];
      4'd7:    hdr_byte = rc[23:16];
      4'd8:    hdr_byte = rc[15:8];
      4'd9:    hdr_byte = rc[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  // Header fields to latch, with oversize / error trimming applied.
  always_comb begin
    w_total    = 17'(payload_size) + 17'(HDR_LEN);
    w_oversize = 32'(w_total) > MAX_RSP_SIZE;
`ifdef TPM_RSP_ERR_TRIM_EN
    w_trim     = w_oversize || (response_code != 32'd0);
`else
    w_trim     = w_oversize;
`endif
    w_rc_n     = w_oversize ? 32'h0000_0095 : response_code;
    w_tag_n    = w_trim ? 16'h8001 : response_tag;
    w_size_n   = w_trim ? 32'(HDR_LEN) : 32'(w_total);
  end

  assign w_hdr_fire = r_out_valid && out_ready;
  assign w_cnt_last = (r_cnt == 16'(r_len - 16'd1));
  assign w_pl_fire  = pl_valid && pl_ready;

  // Control FSM plus the registered header output stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 4'd0;
      r_cnt       <= 16'd0;
      r_len       <= 16'd0;
      r_tag       <= 16'd0;
      r_size      <= 32'd0;
      r_rc        <= 32'd0;
      r_drain     <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_drop_err <= response_valid && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (response_valid) begin
            r_tag       <= w_tag_n;
            r_size      <= w_size_n;
            r_rc        <= w_rc_n;
            r_len       <= payload_size;
            r_drain     <= w_trim;
            r_idx       <= 4'd0;
            r_cnt       <= 16'd0;
            r_out_data  <= w_tag_n[15:8];
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_hdr_fire) begin
            if (r_idx == 4'd9) begin
              r_out_valid <= 1'b0;
              r_out_data  <= 8'h00;
              r_out_last  <= 1'b0;
              if (r_len == 16'd0)  r_state <= S_IDLE;
              else if (r_drain)    r_state <= S_DRAIN;
              else                 r_state <= S_PAYLOAD;
            end else begin
              r_idx      <= 4'(r_idx + 4'd1);
              r_out_data <= hdr_byte(4'(r_idx + 4'd1), r_tag, r_size, r_rc);
              // Byte 9 is the final byte only for a header-only response.
              r_out_last <= (r_idx == 4'd8) && (r_size == 32'(HDR_LEN));
            end
          end
        end
        S_PAYLOAD, S_DRAIN: begin
          if (w_pl_fire) begin
            if (w_cnt_last) begin
              r_cnt   <= 16'd0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= 16'(r_cnt + 16'd1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Payload bytes pass straight through; everything else comes from registers.
  assign out_data  = (r_state == S_PAYLOAD) ? pl_data : r_out_data;
  assign out_valid = (r_state == S_PAYLOAD) ? pl_valid : r_out_valid;
  assign out_last  = (r_state == S_PAYLOAD) ? (pl_valid && w_cnt_last) : r_out_last;
  assign pl_ready  = (r_state == S_PAYLOAD) ? out_ready : (r_state == S_DRAIN);
  assign busy      = (r_state != S_IDLE);
  assign drop_err  = r_drop_err;

endmodule
